// File: rtl/beta_fetch_pc.sv
// beta_fetch_pc: Beta program counter and two-state instruction fetch.
// Ports: clk/reset, irq_in; imem req/addr/ack/data; pcsel, ra_data from
// the decoder; pc, pc_plus4, instr_valid, decoded fields, irq_take out.
`timescale 1ns/1ps
module beta_fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic [2:0]  pcsel,
  input  logic [31:0] ra_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rc,
  output logic [4:0]  ra,
  output logic [4:0]  rb,
  output logic [15:0] literal,
  output logic        irq_take
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic        irq_s1;
  logic        irq_s2;
  logic        irq_s3;
  logic        irq_pending;
  logic        irq_rise;
  logic [30:0] br_off;
  logic [31:0] br_pc;
  logic [31:0] jmp_pc;
  logic [31:0] next_pc;

  // request is killed combinationally so a reset abandons the fetch
  assign imem_req    = (state == FETCH) & ~reset;
  assign imem_addr   = {pc[31:2], 2'b00};
  assign instr_valid = (state == EXEC);

  assign opcode  = ir[31:26];
  assign rc      = ir[25:21];
  assign ra      = ir[20:16];
  assign rb      = ir[15:11];
  assign literal = ir[15:0];

  // supervisor bit rides outside the 31-bit adder
  assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};

  assign br_off = {{13{literal[15]}}, literal, 2'b00};
  assign br_pc  = {pc[31], pc_plus4[30:0] + br_off};

  // JMP may clear the supervisor bit, never set it
  assign jmp_pc = {pc[31] & ra_data[31], ra_data[30:0]}
                & 32'hFFFF_FFFC;

  assign irq_rise = irq_s2 & ~irq_s3;
  assign irq_take = (state == EXEC) & irq_pending & ~pc[31];

  always_comb begin
    next_pc = ILLOP_PC;
    unique case (pcsel)
      3'd0:    next_pc = pc_plus4;
      3'd1:    next_pc = br_pc;
      3'd2:    next_pc = jmp_pc;
      3'd4:    next_pc = XADR_PC;
      default: next_pc = ILLOP_PC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ack) begin
            ir    <= imem_data;
            state <= EXEC;
          end
        end
        EXEC: begin
          pc    <= next_pc & 32'hFFFF_FFFC;
          state <= FETCH;
        end
      endcase
    end
  end

  // a fresh edge beats the clear from a taken interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_s1      <= 1'b0;
      irq_s2      <= 1'b0;
      irq_s3      <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_s1 <= irq_in;
      irq_s2 <= irq_s1;
      irq_s3 <= irq_s2;
      if (irq_rise)
        irq_pending <= 1'b1;
      else if (irq_take)
        irq_pending <= 1'b0;
    end
  end

endmodule
